// File: rtl/sr_latch.sv
// Clocked set/reset latch with NOR-style forbidden state; one-clock command latency,
// registered outputs, async active-low reset with synchronized release.
module sr_latch #(
  parameter logic RESET_Q = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S,
  input  logic R,
  input  logic En,
  output logic Q,
  output logic Qb,
  output logic inv
);

  logic r_run;
  logic r_q;
  logic r_qb;
  logic r_inv;
  logic w_act;
  logic w_bad;
  logic w_set;
  logic w_clr;

  // Arms on the falling edge after release, so a command sitting on the
  // deassertion edge is never taken but the next rising edge is.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign w_act = r_run & En;

  always_comb begin
    w_bad = 1'b0;
    w_set = 1'b0;
    w_clr = 1'b0;
    if (w_act) begin
      if ($isunknown({S, R}) || (S && R)) begin
        w_bad = 1'b1;
      end else if (S) begin
        w_set = 1'b1;
      end else if (R) begin
        w_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= RESET_Q;
      r_qb  <= ~RESET_Q;
      r_inv <= 1'b0;
    end else if (w_bad) begin
      r_q   <= 1'b0;
      r_qb  <= 1'b0;
      r_inv <= 1'b1;
    end else if (w_set) begin
      r_q   <= 1'b1;
      r_qb  <= 1'b0;
      r_inv <= 1'b0;
    end else if (w_clr) begin
      r_q   <= 1'b0;
      r_qb  <= 1'b1;
      r_inv <= 1'b0;
    end
  end

  assign Q   = r_q;
  assign Qb  = r_qb;
  assign inv = r_inv;

endmodule

// File: tb/tb_sr_latch.sv
// Directed plus randomized bench for sr_latch; two instances cover both reset values.
`timescale 1ns/1ps
module tb_sr_latch;

  logic clk;
  logic rst_n;
  logic S;
  logic R;
  logic En;
  logic q0, qb0, inv0;
  logic q1, qb1, inv1;

  int  tests;
  int  fails;
  time t_edge;
  bit  live;
  bit  m_q [2];
  bit  m_forb [2];

  sr_latch #(.RESET_Q(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .S(S), .R(R), .En(En),
    .Q(q0), .Qb(qb0), .inv(inv0)
  );

  sr_latch #(.RESET_Q(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .S(S), .R(R), .En(En),
    .Q(q1), .Qb(qb1), .inv(inv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) t_edge = $time;

  // Outputs may only move on a clock edge or while reset is asserted.
  always @(q0 or qb0 or inv0 or q1 or qb1 or inv1) begin
    tests++;
    assert (($time == t_edge) || (rst_n === 1'b0)) else begin
      fails++;
      $error("FAIL out_timing t=%0t outputs changed off-edge, required change only at clk edge or reset", $time);
    end
  end

  always @(negedge clk) begin
    tests++;
    assert ((inv0 ? (q0 === 1'b0 && qb0 === 1'b0) : (qb0 === ~q0)) &&
            (inv1 ? (q1 === 1'b0 && qb1 === 1'b0) : (qb1 === ~q1))) else begin
      fails++;
      $error("FAIL complement t=%0t d0=%b%b%b d1=%b%b%b required Qb==~Q unless inv", $time,
             q0, qb0, inv0, q1, qb1, inv1);
    end
  end

  function automatic logic [2:0] expv(int k);
    return m_forb[k] ? 3'b001 : {m_q[k], ~m_q[k], 1'b0};
  endfunction

  task automatic chk(string tag, logic [2:0] obs, logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed {Q,Qb,inv}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_both(string tag);
    chk({tag, "/d0"}, {q0, qb0, inv0}, expv(0));
    chk({tag, "/d1"}, {q1, qb1, inv1}, expv(1));
  endtask

  task automatic model_reset();
    m_q[0] = 1'b0;
    m_q[1] = 1'b1;
    m_forb[0] = 1'b0;
    m_forb[1] = 1'b0;
  endtask

  // Reference: an enabled command is judged by its two request bits alone.
  task automatic model_step(bit s, bit r, bit en);
    for (int k = 0; k < 2; k++) begin
      if (live && en && (s || r)) begin
        m_forb[k] = s && r;
        if (!(s && r)) m_q[k] = s;
      end
    end
  endtask

  task automatic do_cycle(string tag, bit s, bit r, bit en);
    @(negedge clk);
    S = s; R = r; En = en;
    @(posedge clk);
    #1;
    model_step(s, r, en);
    check_both(tag);
  endtask

  // Called just after a rising edge: reset is pulsed between edges.
  task automatic mid_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    live = 1'b0;
    check_both({tag, "_imm"});
    @(posedge clk);
    #1;
    check_both({tag, "_held"});
    rst_n = 1'b1;
    live = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    live  = 1'b0;
    t_edge = 0;
    S = 1'b0; R = 1'b0; En = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_both("reset_val");

    // Inputs are ignored while reset is held.
    S = 1'b1; En = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_both("rst_ignore");
    @(negedge clk);
    S = 1'b0; En = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    live = 1'b1;

    for (int i = 0; i < 4; i++) do_cycle("idle", 1'b0, 1'b0, 1'b0);

    do_cycle("clr", 1'b0, 1'b1, 1'b1);
    do_cycle("set", 1'b1, 1'b0, 1'b1);

    do_cycle("forb", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle("forb_hold", 1'b0, 1'b0, 1'b1);
    do_cycle("forb_en0", 1'b0, 1'b1, 1'b0);
    do_cycle("forb_exit", 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) do_cycle("en0_hold", 1'b0, 1'b1, 1'b0);
    do_cycle("en1_clr", 1'b0, 1'b1, 1'b1);

    do_cycle("forb2", 1'b1, 1'b1, 1'b1);
    mid_reset("forb_rst");

    // A command on the very edge where reset releases is not taken.
    @(negedge clk);
    S = 1'b1; R = 1'b0; En = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    live = 1'b0;
    @(posedge clk);
    rst_n = 1'b1;
    #1 check_both("rel_edge");
    live = 1'b1;
    @(posedge clk);
    #1;
    model_step(1'b1, 1'b0, 1'b1);
    check_both("rel_next");

    // Wiggle inputs between edges; nothing may move until the next edge.
    for (int i = 0; i < 3; i++) begin
      #1;
      S = ~S; R = $urandom_range(0, 1); En = ~En;
      check_both("between_edges");
    end
    do_cycle("after_wiggle", 1'b0, 1'b1, 1'b1);

    for (int n = 0; n < 300; n++) begin
      bit s, r, en;
      s  = $urandom_range(0, 1);
      r  = $urandom_range(0, 1);
      en = ($urandom_range(0, 3) != 0);
      do_cycle("rand", s, r, en);
      if ($urandom_range(0, 29) == 0) mid_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
